// File: rtl/mem_key_seq_ctrl_if.sv
// Memory-side bus between the keypad sequencer (master) and the BCD digit memory (slave).
interface mem_key_seq_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              WR;
    logic              RD;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [9:0]        D_OUT;
    logic [3:0]        Q_IN;

    modport master (output WR, RD, MEM_ADDR, D_OUT, input Q_IN);
    modport slave  (input WR, RD, MEM_ADDR, D_OUT, output Q_IN);
endinterface

// File: rtl/mem_key_seq_ctrl.sv
// Keypad record/playback sequencer: key presses become memory writes at incrementing
// addresses, playback sweeps the stored digits back at a fixed tick rate into DISP.
module mem_key_seq_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int TICK_DIV = 1000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [9:0]         KEY,
    input  logic               MODE_PLAY,
    input  logic               CLR,
    mem_key_seq_ctrl_if.master mem,
    output logic [3:0]         DISP,
    output logic               DISP_VALID,
    output logic [ADDR_W:0]    COUNT,
    output logic               FULL,
    output logic               ERR
);
    localparam int                TICK_W      = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W:0]   DEPTH       = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t state, next_state;

    logic [9:0]        key_q, key_qq;
    logic              press_q;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [TICK_W-1:0] tick, tick_next;
    logic [ADDR_W:0]   count_m1;
    logic              key_onehot, q_bad;
    logic              wr_n, rd_n, err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [9:0]        dout_n;
    logic              wr_r, rd_r, err_r;
    logic [ADDR_W-1:0] addr_r;
    logic [9:0]        dout_r;

    // press_q lines up with key_qq, which still holds the key pattern that caused the press
    assign key_onehot = (key_qq != '0) && ((key_qq & (key_qq - 10'd1)) == '0);
    assign q_bad      = mem.Q_IN > 4'd9;
    assign count_m1   = COUNT - (ADDR_W+1)'(1);
    assign FULL       = (COUNT == DEPTH);
    assign tick_next  = (tick == '0) ? '0 : tick - TICK_W'(1);

    assign mem.WR       = wr_r;
    assign mem.RD       = rd_r;
    assign mem.MEM_ADDR = addr_r;
    assign mem.D_OUT    = dout_r;
    assign ERR          = err_r;

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Reads are launched when the decremented tick reaches zero so that RD pulses are
    // exactly TICK_DIV cycles apart despite the registered strobe.
    always_comb begin
        next_state = state;
        wr_n       = 1'b0;
        rd_n       = 1'b0;
        err_n      = 1'b0;
        addr_n     = '0;
        dout_n     = '0;
        case (state)
            IDLE: begin
                if (!MODE_PLAY) begin
                    if (press_q) begin
                        if (key_onehot && !FULL) begin
                            next_state = WRITE;
                            wr_n       = 1'b1;
                            addr_n     = wr_ptr;
                            dout_n     = key_qq;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end else if ((COUNT != '0) && (tick_next == '0)) begin
                    next_state = READ;
                    rd_n       = 1'b1;
                    addr_n     = rd_ptr;
                end
            end
            WRITE: next_state = IDLE;
            READ: begin
                next_state = IDLE;
                err_n      = q_bad;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            key_q      <= '0;
            key_qq     <= '0;
            press_q    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tick       <= '0;
            COUNT      <= '0;
            DISP       <= '0;
            DISP_VALID <= 1'b0;
            wr_r       <= 1'b0;
            rd_r       <= 1'b0;
            err_r      <= 1'b0;
            addr_r     <= '0;
            dout_r     <= '0;
        end else begin
            key_q   <= KEY;
            key_qq  <= key_q;
            press_q <= (key_q != '0) && (key_qq == '0);
            wr_r    <= wr_n;
            rd_r    <= rd_n;
            err_r   <= err_n;
            addr_r  <= addr_n;
            dout_r  <= dout_n;
            case (state)
                IDLE: begin
                    if (!MODE_PLAY) begin
                        tick   <= '0;
                        rd_ptr <= '0;
                    end else begin
                        tick <= tick_next;
                    end
                end
                WRITE: begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    COUNT  <= COUNT + (ADDR_W+1)'(1);
                end
                READ: begin
                    DISP       <= q_bad ? 4'hF : mem.Q_IN;
                    DISP_VALID <= 1'b1;
                    tick       <= TICK_RELOAD;
                    rd_ptr     <= ({1'b0, rd_ptr} == count_m1) ? '0 : rd_ptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_key_seq_ctrl.sv
// Scoreboard bench for mem_key_seq_ctrl: a digit-list model predicts writes, reads and
// error pulses; a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_key_seq_ctrl;
    localparam int ADDR_W   = 4;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RST;
    logic [9:0]        KEY;
    logic              MODE_PLAY;
    logic              CLR;
    logic [3:0]        DISP;
    logic              DISP_VALID;
    logic [ADDR_W:0]   COUNT;
    logic              FULL;
    logic              ERR;

    mem_key_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_key_seq_ctrl #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .KEY        (KEY),
        .MODE_PLAY  (MODE_PLAY),
        .CLR        (CLR),
        .mem        (bus.master),
        .DISP       (DISP),
        .DISP_VALID (DISP_VALID),
        .COUNT      (COUNT),
        .FULL       (FULL),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct { int addr; int dout; int cyc; } wr_item_t;
    typedef struct { int addr; int digit; bit bad; int cyc; } rd_item_t;

    wr_item_t   wr_q[$];
    rd_item_t   rd_q[$];
    int         err_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         flush_edge = 1'b0;
    logic [3:0] mem_arr [DEPTH];
    bit         corrupt [DEPTH];
    int         stored  [DEPTH];
    int         model_count = 0;
    int         model_wr = 0;
    bit         pend = 1'b0;
    bit         pend_bad;
    int         pend_digit;

    always @(posedge CLK) begin
        cyc        <= cyc + 1;
        flush_edge <= RST || CLR;
    end

    function automatic logic [3:0] to_bcd(input logic [9:0] oh);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) if (oh[i]) r = 4'(i);
        return r;
    endfunction

    // Behavioural memory slave: stores BCD digits, read data combinational while RD is high
    always @(posedge CLK) begin
        if (bus.WR === 1'b1) mem_arr[bus.MEM_ADDR] <= to_bcd(bus.D_OUT);
    end
    assign bus.Q_IN = (bus.RD !== 1'b1) ? 4'h0 :
                      (corrupt[bus.MEM_ADDR] ? 4'hC : mem_arr[bus.MEM_ADDR]);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void predictPress(input logic [9:0] key);
        wr_item_t w;
        if ($countones(key) == 1 && model_count < DEPTH) begin
            w.addr = model_wr;
            w.dout = int'(key);
            w.cyc  = cyc + 3;
            wr_q.push_back(w);
            stored[model_wr] = $clog2(int'(key));
            model_wr = (model_wr + 1) % DEPTH;
            model_count++;
        end else begin
            err_q.push_back(cyc + 3);
        end
    endfunction

    function automatic void flushModel();
        wr_q.delete();
        rd_q.delete();
        err_q.delete();
        model_count = 0;
        model_wr    = 0;
    endfunction

    task automatic applyStimulus(input logic [9:0] key, input int hold);
        @(negedge CLK);
        KEY = key;
        if (!MODE_PLAY) predictPress(key);
        repeat (hold) @(negedge CLK);
        KEY = '0;
        repeat (4) @(negedge CLK);
    endtask

    function automatic logic [9:0] randomKey(input bit allow_multi);
        int d, d2;
        logic [9:0] k;
        d = $urandom_range(9, 0);
        k = 10'd1 << d;
        if (allow_multi && $urandom_range(3, 0) == 0) begin
            d2 = (d + 1 + $urandom_range(8, 0)) % 10;
            k  = k | (10'd1 << d2);
        end
        return k;
    endfunction

    task automatic waitReads(input int budget);
        while ((rd_q.size() > 0 || pend) && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (budget == 0) begin
            checkOutput("read_timeout", rd_q.size(), 0);
            rd_q.delete();
        end
    endtask

    task automatic playSession(input int k, input bit press_mid);
        rd_item_t r;
        int       last;
        last = 0;
        @(negedge CLK);
        MODE_PLAY = 1'b1;
        if (model_count > 0) begin
            for (int i = 0; i < k; i++) begin
                r.addr  = i % model_count;
                r.bad   = corrupt[r.addr];
                r.digit = r.bad ? 15 : stored[r.addr];
                r.cyc   = cyc + 1 + i * TICK_DIV;
                rd_q.push_back(r);
                last = r.digit;
            end
        end
        if (press_mid) applyStimulus(randomKey(1'b1), 3);
        waitReads(k * TICK_DIV + 20);
        MODE_PLAY = 1'b0;
        repeat (3) @(negedge CLK);
        if (model_count > 0 && k > 0) checkOutput("disp_hold", DISP, last);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write, read or error pulse
    initial begin
        wr_item_t w;
        rd_item_t r;
        int       e;
        forever begin
            @(negedge CLK);
            if (pend && !flush_edge) begin
                checkOutput("disp", DISP, pend_digit);
                checkOutput("disp_valid", DISP_VALID, 1);
                checkOutput("read_err", ERR, pend_bad);
            end else if (ERR === 1'b1 && !flush_edge) begin
                if (err_q.size() == 0) begin
                    checkOutput("unexpected_err", ERR, 0);
                end else begin
                    e = err_q.pop_front();
                    checkOutput("err_cycle", cyc, e);
                end
            end
            pend = 1'b0;
            if (bus.WR === 1'b1) begin
                checkOutput("wr_rd_exclusive", bus.RD, 0);
                if (wr_q.size() == 0) begin
                    checkOutput("unexpected_wr", bus.WR, 0);
                end else begin
                    w = wr_q.pop_front();
                    checkOutput("wr_addr", bus.MEM_ADDR, w.addr);
                    checkOutput("wr_data", bus.D_OUT, w.dout);
                    checkOutput("wr_cycle", cyc, w.cyc);
                end
            end else if (bus.RD === 1'b1) begin
                if (rd_q.size() == 0) begin
                    checkOutput("unexpected_rd", bus.RD, 0);
                end else begin
                    r = rd_q.pop_front();
                    checkOutput("rd_addr", bus.MEM_ADDR, r.addr);
                    checkOutput("rd_cycle", cyc, r.cyc);
                    pend       = 1'b1;
                    pend_digit = r.digit;
                    pend_bad   = r.bad;
                end
            end else begin
                checkOutput("idle_bus", {bus.MEM_ADDR, bus.D_OUT}, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            mem_arr[i] = 4'h0;
            corrupt[i] = 1'b0;
            stored[i]  = 0;
        end
        RST       = 1'b1;
        KEY       = '0;
        MODE_PLAY = 1'b0;
        CLR       = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_count", COUNT, 0);
        checkOutput("rst_full", FULL, 0);
        checkOutput("rst_disp", DISP, 0);
        checkOutput("rst_disp_valid", DISP_VALID, 0);
        checkOutput("rst_err", ERR, 0);
        checkOutput("rst_wr_rd", {bus.WR, bus.RD}, 0);
        RST = 1'b0;

        $display("[TB] held single key");
        applyStimulus(10'b0000001000, 40);
        checkOutput("count_single", COUNT, 1);

        $display("[TB] multi-key rejection then digit 9");
        applyStimulus(10'b0000000011, 10);
        checkOutput("count_after_reject", COUNT, 1);
        applyStimulus(10'b1000000000, 5);

        $display("[TB] fill to capacity");
        n = 0;
        while (model_count < DEPTH && n < 100) begin
            applyStimulus(randomKey(1'b1), $urandom_range(6, 1));
            n++;
        end
        checkOutput("count_full", COUNT, DEPTH);
        checkOutput("full_flag", FULL, 1);
        applyStimulus(10'b0000010000, 5);
        applyStimulus(10'b0010010001, 5);
        checkOutput("count_still_full", COUNT, DEPTH);

        $display("[TB] playback of full memory with wrap");
        playSession(DEPTH + 2, 1'b1);

        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        flushModel();
        checkOutput("clr_count", COUNT, 0);
        checkOutput("clr_disp_valid", DISP_VALID, 0);

        $display("[TB] record 7,2,5 and play");
        applyStimulus(10'b0010000000, 3);
        applyStimulus(10'b0000000100, 3);
        applyStimulus(10'b0000100000, 3);
        playSession(4, 1'b0);

        $display("[TB] out-of-range read data");
        corrupt[1] = 1'b1;
        playSession(5, 1'b0);
        corrupt[1] = 1'b0;

        $display("[TB] clear during playback");
        @(negedge CLK);
        MODE_PLAY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_q.push_back('{addr: i % model_count, digit: stored[i % model_count], bad: 1'b0,
                             cyc: cyc + 1 + i * TICK_DIV});
        end
        budget = 40;
        while (rd_q.size() > 4 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        checkOutput("clr_wait_reads", rd_q.size() <= 4, 1);
        CLR = 1'b1;
        @(negedge CLK);
        checkOutput("clr_play_count", COUNT, 0);
        checkOutput("clr_play_full", FULL, 0);
        checkOutput("clr_play_wr_rd", {bus.WR, bus.RD}, 0);
        checkOutput("clr_play_disp_valid", DISP_VALID, 0);
        CLR       = 1'b0;
        MODE_PLAY = 1'b0;
        flushModel();
        repeat (2) @(negedge CLK);
        applyStimulus(10'b0000010000, 3);
        checkOutput("count_after_clr", COUNT, 1);

        $display("[TB] reset during write");
        @(negedge CLK);
        KEY = 10'b0001000000;
        predictPress(KEY);
        budget = 10;
        while (bus.WR !== 1'b1 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        checkOutput("rst_write_seen", bus.WR, 1);
        RST = 1'b1;
        KEY = '0;
        @(negedge CLK);
        checkOutput("rst_write_count", COUNT, 0);
        checkOutput("rst_write_full", FULL, 0);
        checkOutput("rst_write_wr_rd", {bus.WR, bus.RD}, 0);
        RST = 1'b0;
        flushModel();
        repeat (2) @(negedge CLK);
        applyStimulus(10'b0000000100, 3);

        $display("[TB] randomized record/play rounds");
        for (int round = 0; round < 4; round++) begin
            n = $urandom_range(8, 3);
            for (int p = 0; p < n; p++) applyStimulus(randomKey(1'b1), $urandom_range(6, 1));
            checkOutput("round_count", COUNT, model_count);
            playSession($urandom_range(10, 2), bit'($urandom_range(1, 0)));
        end

        repeat (10) @(negedge CLK);
        checkOutput("wr_queue_empty", wr_q.size(), 0);
        checkOutput("rd_queue_empty", rd_q.size(), 0);
        checkOutput("err_queue_empty", err_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
